// File: rtl/agc_pkg.sv
// Shared constants and decode helpers for the AGC core slice.
`timescale 1ns/1ps
package agc_pkg;

  localparam int unsigned TP_COUNT = 12;
  localparam int unsigned T05_IDX  = 4;
  localparam int unsigned T12_IDX  = 11;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned XT_W     = 7;
  localparam int unsigned XB_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_A    = 6'd0;
  localparam logic [ADDR_W-1:0] ADDR_L    = 6'd1;
  localparam logic [ADDR_W-1:0] ADDR_Q    = 6'd2;
  localparam logic [ADDR_W-1:0] ADDR_EB   = 6'd3;
  localparam logic [ADDR_W-1:0] ADDR_FB   = 6'd4;
  localparam logic [ADDR_W-1:0] ADDR_Z    = 6'd5;
  localparam logic [ADDR_W-1:0] ADDR_BB   = 6'd6;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = 6'd7;

  localparam logic [DATA_W-1:0]   RESTART_Z_DEFAULT = 16'o4000;
  localparam logic [TP_COUNT-1:0] TP_T01            = 12'b0000_0000_0001;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/agc_timepulse.sv
// Timepulse ring with monitor-stop hold, plus GOJAM restart set/clear logic.
`timescale 1ns/1ps
module agc_timepulse
  import agc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                strt,
  input  logic                mstp,
  output logic [TP_COUNT-1:0] tp,
  output logic                mct_end,
  output logic                gojam
);

  logic [TP_COUNT-1:0] tp_q, tp_d;
  logic                gojam_q, gojam_d;
  logic                flag_q, flag_d;
  logic                wrap, rise;

  assign wrap = tp_q[T12_IDX] & ~mstp;
  assign rise = strt & ~gojam_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q    <= TP_T01;
      gojam_q <= 1'b1;
      flag_q  <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      gojam_q <= gojam_d;
      flag_q  <= flag_d;
    end
  end

  // flag_q remembers any restart request seen during the current MCT
  always_comb begin
    tp_d    = {tp_q[TP_COUNT-2:0], tp_q[TP_COUNT-1]};
    gojam_d = gojam_q;
    flag_d  = flag_q | strt;
    if (tp_q[T12_IDX] && mstp) tp_d = tp_q;
    if (wrap && !(flag_q || strt)) gojam_d = 1'b0;
    if (strt) gojam_d = 1'b1;
    if (rise) tp_d = TP_T01;
    if (wrap || rise) flag_d = 1'b0;
  end

  always_comb begin
    tp      = tp_q;
    mct_end = tp_q[T12_IDX];
    gojam   = gojam_q;
  end

endmodule

// File: rtl/agc_slice.sv
// AGC core slice top: backplane-named ports, address decode and the eight
// central registers at addresses 0-7; timing and restart live in agc_timepulse.
`timescale 1ns/1ps
module agc_slice
  import agc_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESTART_Z = RESTART_Z_DEFAULT
) (
  input  logic CLOCK,
  input  logic SIM_RST,
  input  logic VCC,
  input  logic GND,
  input  logic STRT1,
  input  logic STRT2,
  input  logic MSTP,
  input  logic WL01_n, input logic WL02_n, input logic WL03_n, input logic WL04_n,
  input  logic WL05_n, input logic WL06_n, input logic WL07_n, input logic WL08_n,
  input  logic WL09_n, input logic WL10_n, input logic WL11_n, input logic WL12_n,
  input  logic WL13_n, input logic WL14_n, input logic WL15_n, input logic WL16_n,
  input  logic WL15,   input logic WL16,
  input  logic XT0_n,  input logic XT1_n,  input logic XT2_n,  input logic XT3_n,
  input  logic XT4_n,  input logic XT5_n,  input logic XT6_n,
  input  logic XB0_n,  input logic XB1_n,  input logic XB2_n,  input logic XB3_n,
  input  logic XB4_n,  input logic XB5_n,  input logic XB6_n,  input logic XB7_n,
  input  logic ALGA, input logic C24A, input logic C25A, input logic C26A,
  input  logic C27A, input logic C30A, input logic C37P, input logic C40P,
  input  logic C41P, input logic C42P, input logic C43P, input logic C44P,
  input  logic CDUSTB_n, input logic CHINC_n, input logic CYL_n, input logic CYR_n,
  input  logic DINC, input logic DINC_n, input logic EAC_n, input logic EDOP_n,
  input  logic EXTPLS, input logic FETCH0, input logic FETCH0_n, input logic FETCH1,
  input  logic GEQZRO_n, input logic GINH, input logic INCSET_n, input logic INHPLS,
  input  logic INKL, input logic INKL_n, input logic INOTLD, input logic L01_n,
  input  logic L02A_n, input logic L15A_n, input logic L15_n, input logic MCDU,
  input  logic MINC, input logic MNHRPT, input logic MONPCH, input logic MONWBK,
  input  logic MON_n, input logic MSTRTP, input logic MTCSAI, input logic OVNHRP,
  input  logic PCDU, input logic PIPPLS_n, input logic RADRG, input logic RADRZ,
  input  logic RCHAT_n, input logic RCHBT_n, input logic RELPLS, input logic RUPTOR_n,
  input  logic S11, input logic S12, input logic SBY, input logic SHANC_n,
  input  logic SHIFT, input logic SHIFT_n, input logic SR_n, input logic STBE,
  input  logic STBF, input logic STFET1_n, input logic STORE1_n, input logic SUMA16_n,
  input  logic SUMB16_n, input logic YB0_n, input logic YT0_n,
  output logic [TP_COUNT-1:0] TP,
  output logic                MCT_END,
  output logic                GOJAM,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                RD_VALID
);

  logic unused_ok;
  assign unused_ok = ^{VCC, GND, WL15, WL16, ALGA, C24A, C25A, C26A, C27A, C30A,
                       C37P, C40P, C41P, C42P, C43P, C44P, CDUSTB_n, CHINC_n, CYL_n,
                       CYR_n, DINC, DINC_n, EAC_n, EDOP_n, EXTPLS, FETCH0, FETCH0_n,
                       FETCH1, GEQZRO_n, GINH, INCSET_n, INHPLS, INKL, INKL_n, INOTLD,
                       L01_n, L02A_n, L15A_n, L15_n, MCDU, MINC, MNHRPT, MONPCH,
                       MONWBK, MON_n, MSTRTP, MTCSAI, OVNHRP, PCDU, PIPPLS_n, RADRG,
                       RADRZ, RCHAT_n, RCHBT_n, RELPLS, RUPTOR_n, S11, S12, SBY,
                       SHANC_n, SHIFT, SHIFT_n, SR_n, STBE, STBF, STFET1_n, STORE1_n,
                       SUMA16_n, SUMB16_n, YB0_n, YT0_n};

  logic [TP_COUNT-1:0] tp;
  logic                gojam;

  agc_timepulse u_tp (
    .clk     (CLOCK),
    .rst     (SIM_RST),
    .strt    (STRT1 | STRT2),
    .mstp    (MSTP),
    .tp      (tp),
    .mct_end (MCT_END),
    .gojam   (gojam)
  );

  assign TP    = tp;
  assign GOJAM = gojam;

  logic [XT_W-1:0]   xt;
  logic [XB_W-1:0]   xb;
  logic [DATA_W-1:0] wdata;
  logic              legal, we;
  logic [ADDR_W-1:0] addr;

  assign xt    = ~{XT6_n, XT5_n, XT4_n, XT3_n, XT2_n, XT1_n, XT0_n};
  assign xb    = ~{XB7_n, XB6_n, XB5_n, XB4_n, XB3_n, XB2_n, XB1_n, XB0_n};
  assign wdata = ~{WL16_n, WL15_n, WL14_n, WL13_n, WL12_n, WL11_n, WL10_n, WL09_n,
                   WL08_n, WL07_n, WL06_n, WL05_n, WL04_n, WL03_n, WL02_n, WL01_n};

  always_comb begin
    legal    = is_onehot({1'b0, xt}) && is_onehot(xb);
    addr     = {enc8({1'b0, xt}), enc8(xb)};
    RD_VALID = legal && (addr <= ADDR_ZERO);
    we       = tp[T05_IDX] && !gojam && legal && (addr <= ADDR_BB);
  end

  // EB and FB hold only their bank fields; BB is a view of both
  logic [DATA_W-1:0] a_q, a_d, l_q, l_d, q_q, q_d, z_q, z_d;
  logic [2:0]        eb_q, eb_d;
  logic [4:0]        fb_q, fb_d;

  always_ff @(posedge CLOCK or posedge SIM_RST) begin
    if (SIM_RST) begin
      a_q  <= '0;
      l_q  <= '0;
      q_q  <= '0;
      z_q  <= RESTART_Z;
      eb_q <= '0;
      fb_q <= '0;
    end else begin
      a_q  <= a_d;
      l_q  <= l_d;
      q_q  <= q_d;
      z_q  <= z_d;
      eb_q <= eb_d;
      fb_q <= fb_d;
    end
  end

  always_comb begin
    a_d  = a_q;
    l_d  = l_q;
    q_d  = q_q;
    z_d  = z_q;
    eb_d = eb_q;
    fb_d = fb_q;
    if (we) begin
      case (addr)
        ADDR_A:  a_d = wdata;
        ADDR_L:  l_d = wdata;
        ADDR_Q:  q_d = wdata;
        ADDR_EB: eb_d = wdata[10:8];
        ADDR_FB: fb_d = wdata[14:10];
        ADDR_Z:  z_d = wdata;
        ADDR_BB: begin
          eb_d = wdata[2:0];
          fb_d = wdata[14:10];
        end
        default: ;
      endcase
    end
    if (gojam) z_d = RESTART_Z;
  end

  always_comb begin
    RD_DATA = '0;
    if (RD_VALID) begin
      case (addr)
        ADDR_A:  RD_DATA = a_q;
        ADDR_L:  RD_DATA = l_q;
        ADDR_Q:  RD_DATA = q_q;
        ADDR_EB: RD_DATA = {5'b0, eb_q, 8'b0};
        ADDR_FB: RD_DATA = {1'b0, fb_q, 10'b0};
        ADDR_Z:  RD_DATA = z_q;
        ADDR_BB: RD_DATA = {1'b0, fb_q, 7'b0, eb_q};
        default: RD_DATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_slice.sv
// Directed self-checking bench for agc_slice.
`timescale 1ns/1ps
module tb_agc_slice;

  logic        CLOCK = 1'b0;
  logic        SIM_RST, STRT1, STRT2, MSTP;
  logic [15:0] wl_n;
  logic [6:0]  xt_n;
  logic [7:0]  xb_n;
  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;
  logic [11:0] TP;
  logic        MCT_END, GOJAM, RD_VALID;
  logic [15:0] RD_DATA;

  int n_tests = 0;
  int n_fail  = 0;

  always #488.281 CLOCK = ~CLOCK;

  agc_slice dut (
    .CLOCK(CLOCK), .SIM_RST(SIM_RST), .VCC(tie1), .GND(tie0),
    .STRT1(STRT1), .STRT2(STRT2), .MSTP(MSTP),
    .WL01_n(wl_n[0]),  .WL02_n(wl_n[1]),  .WL03_n(wl_n[2]),  .WL04_n(wl_n[3]),
    .WL05_n(wl_n[4]),  .WL06_n(wl_n[5]),  .WL07_n(wl_n[6]),  .WL08_n(wl_n[7]),
    .WL09_n(wl_n[8]),  .WL10_n(wl_n[9]),  .WL11_n(wl_n[10]), .WL12_n(wl_n[11]),
    .WL13_n(wl_n[12]), .WL14_n(wl_n[13]), .WL15_n(wl_n[14]), .WL16_n(wl_n[15]),
    .WL15(tie0), .WL16(tie0),
    .XT0_n(xt_n[0]), .XT1_n(xt_n[1]), .XT2_n(xt_n[2]), .XT3_n(xt_n[3]),
    .XT4_n(xt_n[4]), .XT5_n(xt_n[5]), .XT6_n(xt_n[6]),
    .XB0_n(xb_n[0]), .XB1_n(xb_n[1]), .XB2_n(xb_n[2]), .XB3_n(xb_n[3]),
    .XB4_n(xb_n[4]), .XB5_n(xb_n[5]), .XB6_n(xb_n[6]), .XB7_n(xb_n[7]),
    .ALGA(tie0), .C24A(tie0), .C25A(tie0), .C26A(tie0), .C27A(tie0), .C30A(tie0),
    .C37P(tie0), .C40P(tie0), .C41P(tie0), .C42P(tie0), .C43P(tie0), .C44P(tie0),
    .CDUSTB_n(tie1), .CHINC_n(tie1), .CYL_n(tie1), .CYR_n(tie1), .DINC(tie0),
    .DINC_n(tie1), .EAC_n(tie1), .EDOP_n(tie1), .EXTPLS(tie0), .FETCH0(tie0),
    .FETCH0_n(tie1), .FETCH1(tie0), .GEQZRO_n(tie1), .GINH(tie0), .INCSET_n(tie1),
    .INHPLS(tie0), .INKL(tie0), .INKL_n(tie1), .INOTLD(tie0), .L01_n(tie1),
    .L02A_n(tie1), .L15A_n(tie1), .L15_n(tie1), .MCDU(tie0), .MINC(tie0),
    .MNHRPT(tie0), .MONPCH(tie0), .MONWBK(tie0), .MON_n(tie1), .MSTRTP(tie0),
    .MTCSAI(tie0), .OVNHRP(tie0), .PCDU(tie0), .PIPPLS_n(tie1), .RADRG(tie0),
    .RADRZ(tie0), .RCHAT_n(tie1), .RCHBT_n(tie1), .RELPLS(tie0), .RUPTOR_n(tie1),
    .S11(tie0), .S12(tie0), .SBY(tie0), .SHANC_n(tie1), .SHIFT(tie0),
    .SHIFT_n(tie1), .SR_n(tie1), .STBE(tie0), .STBF(tie0), .STFET1_n(tie1),
    .STORE1_n(tie1), .SUMA16_n(tie1), .SUMB16_n(tie1), .YB0_n(tie1), .YT0_n(tie1),
    .TP(TP), .MCT_END(MCT_END), .GOJAM(GOJAM), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o, expected %0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_addr(input int t, input int b);
    xt_n    = '1;
    xb_n    = '1;
    xt_n[t] = 1'b0;
    xb_n[b] = 1'b0;
    #1;
  endtask

  // advance to the given timepulse index, bounded
  task automatic wait_tp(input int idx);
    int n;
    logic [11:0] want;
    want = 12'd1 << idx;
    n = 0;
    while (TP !== want && n < 40) begin
      tick();
      n++;
    end
    chk("wait_tp", 32'(TP === want), 32'd1);
  endtask

  // present the write, cross the edge leaving T05, drop the data
  task automatic wr(input int t, input int b, input logic [15:0] d);
    set_addr(t, b);
    wl_n = ~d;
    wait_tp(4);
    tick();
    wl_n = '1;
    #1;
  endtask

  task automatic rd(input string tag, input int t, input int b, input logic [15:0] exp);
    set_addr(t, b);
    chk(tag, 32'(RD_DATA), 32'(exp));
  endtask

  initial begin
    SIM_RST = 1'b1;
    STRT1 = 1'b0;
    STRT2 = 1'b0;
    MSTP  = 1'b0;
    wl_n  = '1;
    xt_n  = '1;
    xb_n  = '1;
    #10;
    chk("rst_tp", 32'(TP), 32'd1);
    chk("rst_gojam", 32'(GOJAM), 32'd1);
    chk("rst_mct_end", 32'(MCT_END), 32'd0);
    rd("rst_z", 0, 5, 16'o4000);
    rd("rst_a", 0, 0, 16'o0);
    #4990;
    SIM_RST = 1'b0;

    // first MCT after reset is clean, so GOJAM drops at its end
    for (int i = 1; i < 12; i++) begin
      tick();
      chk("tp_seq", 32'(TP), 32'd1 << i);
    end
    chk("t12_mct_end", 32'(MCT_END), 32'd1);
    chk("t12_gojam", 32'(GOJAM), 32'd1);
    tick();
    chk("wrap_tp", 32'(TP), 32'd1);
    chk("gojam_clear", 32'(GOJAM), 32'd0);

    // write A and see the change only after leaving T05
    set_addr(0, 0);
    wl_n = ~16'o30000;
    #1;
    chk("a_before", 32'(RD_DATA), 32'd0);
    wait_tp(4);
    chk("a_at_t05", 32'(RD_DATA), 32'd0);
    tick();
    chk("a_after", 32'(RD_DATA), 32'(16'o30000));
    wl_n = '1;

    wr(0, 4, 16'o76000);
    rd("fb", 0, 4, 16'o76000);
    rd("bb_from_fb", 0, 6, 16'o76000);
    wr(0, 3, 16'o1400);
    rd("eb", 0, 3, 16'o1400);
    rd("bb_from_eb", 0, 6, 16'o76003);
    wr(0, 6, 16'o12345);
    rd("eb_from_bb", 0, 3, 16'o2400);
    rd("fb_from_bb", 0, 4, 16'o12000);
    rd("bb", 0, 6, 16'o12005);
    wr(0, 1, 16'o000001);
    rd("l", 0, 1, 16'o000001);
    wr(0, 2, 16'o177777);
    rd("q", 0, 2, 16'o177777);
    wr(0, 5, 16'o1234);
    rd("z", 0, 5, 16'o1234);

    // two tens lines low: illegal, no read, no write
    xt_n = 7'b1111100;
    xb_n = 8'b1111_1110;
    wl_n = ~16'o177777;
    #1;
    chk("illegal_valid", 32'(RD_VALID), 32'd0);
    chk("illegal_data", 32'(RD_DATA), 32'd0);
    wait_tp(4);
    tick();
    wl_n = '1;
    rd("a_after_illegal", 0, 0, 16'o30000);

    wr(0, 7, 16'o55555);
    chk("zero_valid", 32'(RD_VALID), 32'd1);
    chk("zero_data", 32'(RD_DATA), 32'd0);
    wr(1, 0, 16'o55555);
    chk("addr8_valid", 32'(RD_VALID), 32'd0);
    chk("addr8_data", 32'(RD_DATA), 32'd0);
    rd("a_after_addr8", 0, 0, 16'o30000);

    // monitor stop holds T12
    wait_tp(11);
    MSTP = 1'b1;
    repeat (3) tick();
    chk("mstp_tp", 32'(TP), 32'd1 << 11);
    chk("mstp_mct_end", 32'(MCT_END), 32'd1);
    MSTP = 1'b0;
    tick();
    chk("mstp_release_tp", 32'(TP), 32'd1);
    chk("mstp_release_end", 32'(MCT_END), 32'd0);

    // restart mid-MCT with a write to A pending throughout
    set_addr(0, 0);
    wl_n = ~16'o777;
    wait_tp(3);
    STRT1 = 1'b1;
    tick();
    chk("strt_snap_tp", 32'(TP), 32'd1);
    chk("strt_gojam", 32'(GOJAM), 32'd1);
    repeat (3) tick();
    chk("strt_held_tp", 32'(TP), 32'd1 << 3);
    STRT1 = 1'b0;
    repeat (20) tick();
    chk("dirty_mct_tp", 32'(TP), 32'd1 << 11);
    chk("dirty_mct_gojam", 32'(GOJAM), 32'd1);
    tick();
    chk("restart_end_tp", 32'(TP), 32'd1);
    chk("restart_end_gojam", 32'(GOJAM), 32'd0);
    chk("a_suppressed", 32'(RD_DATA), 32'(16'o30000));
    wl_n = '1;
    rd("z_forced", 0, 5, 16'o4000);
    xt_n = '1;
    xb_n = '1;

    // asynchronous reset in the middle of an MCT
    wait_tp(6);
    SIM_RST = 1'b1;
    #5;
    chk("midrst_tp", 32'(TP), 32'd1);
    chk("midrst_gojam", 32'(GOJAM), 32'd1);
    rd("midrst_a", 0, 0, 16'o0);
    rd("midrst_fb", 0, 4, 16'o0);
    rd("midrst_z", 0, 5, 16'o4000);
    SIM_RST = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
